// File: rtl/mux_arb_param.sv
// mux_arb_param: parameterised N-channel multiplexer/arbiter with one output register.
// Mode 0 passes the channel named by selector, if that channel is valid.
// Mode 1 picks a channel round-robin, starting the search at the internal pointer.
// The output register takes a new transfer whenever it is empty or being drained.
// ack_out tells the chosen channel, combinationally, that its data is consumed
// at the next rising edge.

module mux_arb_param #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      mode,
    input  logic [SELW-1:0]           selector,
    input  logic [WIDTH*CHANNELS-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic                      ready_in,
    output logic [CHANNELS-1:0]       ack_out,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SELW-1:0]           grant_out,
    output logic [7:0]                count_out
);

    // Round-robin pointer: the first channel examined in mode 1.
    logic [SELW-1:0]  ptr;

    // Each channel's data as an array, so the candidate is picked by index.
    logic [WIDTH-1:0] chan_data [CHANNELS];

    // Round-robin search results.
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  rr_try;

    // Fixed-selection result.
    logic             fix_found;

    // Candidate after the mode has been applied.
    logic             cand_found;
    logic [SELW-1:0]  cand_idx;
    logic [WIDTH-1:0] cand_data;

    // Handshake terms.
    logic             out_free;
    logic             load;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_split
            assign chan_data[g] = data_in[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Find the first valid channel at or after ptr, wrapping modulo CHANNELS.
    // The SELW-bit sum wraps by itself because CHANNELS is a power of two.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_try   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rr_try = ptr + SELW'(i);
            if (!rr_found && valid_in[rr_try]) begin
                rr_found = 1'b1;
                rr_idx   = rr_try;
            end
        end
    end

    // In mode 0 only the selected channel counts; other valid channels are ignored.
    assign fix_found = valid_in[selector];

    // Apply the mode. A mode change acts in the same cycle.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        if (mode) begin
            cand_found = rr_found;
            cand_idx   = rr_idx;
        end else begin
            cand_found = fix_found;
            cand_idx   = selector;
        end
    end

    assign cand_data = chan_data[cand_idx];

    // The register can take new data when it is empty or is being read this cycle.
    // Loading is blocked during reset, so ack_out stays zero while reset_L is low.
    assign out_free = !valid_out || ready_in;
    assign load     = reset_L && out_free && cand_found;

    // Acknowledge the chosen channel, one-hot, only when it is actually loaded.
    always_comb begin
        ack_out = '0;
        if (load) begin
            ack_out[cand_idx] = 1'b1;
        end
    end

    // Output register: load a transfer, drain the register, or hold during a stall.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant_out <= '0;
            count_out <= '0;
        end else if (load) begin
            data_out  <= cand_data;
            valid_out <= 1'b1;
            grant_out <= cand_idx;
            count_out <= count_out + 8'd1;
        end else if (ready_in) begin
            // Drained with nothing to replace it: data_out and grant_out keep their last values.
            valid_out <= 1'b0;
        end
    end

    // Advance the pointer past the channel just served, on mode 1 loads only.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (load && mode) begin
            ptr <= cand_idx + SELW'(1);
        end
    end

endmodule

// File: tb/tb_mux_arb_param.sv
// Testbench for mux_arb_param with WIDTH=2, CHANNELS=4.
// Runs fixed vectors, hand-written corner sequences and random stimulus.
// Every check compares against a behavioural model or against constants.

module tb_mux_arb_param;

    localparam int W  = 2;
    localparam int C  = 4;
    localparam int SW = 2;

    logic          clk;
    logic          reset_L;
    logic          mode;
    logic [SW-1:0] selector;
    logic [W*C-1:0] data_in;
    logic [C-1:0]  valid_in;
    logic          ready_in;
    logic [C-1:0]  ack_out;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic [SW-1:0] grant_out;
    logic [7:0]    count_out;

    int n_chk = 0;
    int n_err = 0;

    // Model state, written directly from the behavioural rules.
    int m_valid, m_data, m_grant, m_count, m_ptr;

    mux_arb_param #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .mode      (mode),
        .selector  (selector),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .ack_out   (ack_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_out (grant_out),
        .count_out (count_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Chosen channel, or -1. Mode 1 takes the valid channel at the smallest
    // forward distance from the pointer.
    function automatic int pick(input int md, input int sel, input int vin, input int p);
        int best, bestd, d;
        if (md == 0) begin
            return (((vin >> sel) & 1) != 0) ? sel : -1;
        end
        best  = -1;
        bestd = C;
        for (int k = 0; k < C; k++) begin
            if (((vin >> k) & 1) != 0) begin
                d = (k - p + C) % C;
                if (d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
        end
        return best;
    endfunction

    function automatic int model_ack(input int md, input int sel, input int vin, input int rdy);
        int idx;
        idx = pick(md, sel, vin, m_ptr);
        if ((m_valid == 0 || rdy != 0) && idx >= 0) return 1 << idx;
        return 0;
    endfunction

    task automatic model_clock(input int md, input int sel, input int vin, input int din, input int rdy);
        int idx;
        idx = pick(md, sel, vin, m_ptr);
        if ((m_valid == 0 || rdy != 0) && idx >= 0) begin
            m_data  = (din >> (idx * W)) & ((1 << W) - 1);
            m_valid = 1;
            m_grant = idx;
            m_count = (m_count + 1) % 256;
            if (md != 0) m_ptr = (idx + 1) % C;
        end else if (rdy != 0) begin
            m_valid = 0;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_grant = 0; m_count = 0; m_ptr = 0;
    endtask

    task automatic drive(input int md, input int sel, input int vin, input int din, input int rdy);
        mode     = md[0];
        selector = sel[SW-1:0];
        valid_in = vin[C-1:0];
        data_in  = din[W*C-1:0];
        ready_in = rdy[0];
    endtask

    // One cycle checked against the model: ack before the edge, registers after it.
    task automatic step(input int md, input int sel, input int vin, input int din, input int rdy);
        drive(md, sel, vin, din, rdy);
        #1;
        chk("ack_out", ack_out, model_ack(md, sel, vin, rdy));
        @(posedge clk);
        model_clock(md, sel, vin, din & 8'hFF, rdy);
        #1;
        chk("valid_out", valid_out, m_valid);
        chk("data_out",  data_out,  m_data);
        chk("grant_out", grant_out, m_grant);
        chk("count_out", count_out, m_count);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ack_out"},   ack_out,   0);
        chk({tag, " valid_out"}, valid_out, 0);
        chk({tag, " data_out"},  data_out,  0);
        chk({tag, " grant_out"}, grant_out, 0);
        chk({tag, " count_out"}, count_out, 0);
    endtask

    // Assert reset with valid inputs present, check it clears, release between edges.
    task automatic do_reset();
        reset_L = 1'b0;
        drive(1, 0, 4'hF, 8'hE4, 1);
        #3;
        check_zero("reset");
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int md; int sel; int vin; int din; int rdy;
        int e_ack; int e_valid; int e_data; int e_grant; int e_count;
    } vec_t;

    vec_t tbl[12];
    int   g_exp[5];

    initial begin
        // mode sel valid data rdy | ack valid data grant count
        tbl[0]  = '{0, 2, 4'b0110, 8'h30, 1, 4'b0100, 1, 3, 2, 1};
        tbl[1]  = '{0, 0, 4'b0110, 8'hE4, 1, 4'b0000, 0, 3, 2, 1};
        tbl[2]  = '{1, 0, 4'b1111, 8'hE4, 0, 4'b0001, 1, 0, 0, 2};
        tbl[3]  = '{1, 0, 4'b1111, 8'hE4, 0, 4'b0000, 1, 0, 0, 2};
        tbl[4]  = '{1, 0, 4'b1111, 8'hE4, 0, 4'b0000, 1, 0, 0, 2};
        tbl[5]  = '{1, 0, 4'b1001, 8'hE4, 1, 4'b1000, 1, 3, 3, 3};
        tbl[6]  = '{1, 0, 4'b1001, 8'hE4, 1, 4'b0001, 1, 0, 0, 4};
        tbl[7]  = '{0, 3, 4'b1000, 8'hE4, 1, 4'b1000, 1, 3, 3, 5};
        tbl[8]  = '{1, 0, 4'b1111, 8'hE4, 1, 4'b0010, 1, 1, 1, 6};
        tbl[9]  = '{1, 0, 4'b0000, 8'hE4, 1, 4'b0000, 0, 1, 1, 6};
        tbl[10] = '{1, 0, 4'b0000, 8'hE4, 0, 4'b0000, 0, 1, 1, 6};
        tbl[11] = '{1, 0, 4'b0101, 8'hE4, 0, 4'b0100, 1, 2, 2, 7};
        g_exp = '{0, 1, 2, 3, 0};

        reset_L = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        // Fixed vectors, applied back to back from reset.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].md, tbl[i].sel, tbl[i].vin, tbl[i].din, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d ack", i), ack_out, tbl[i].e_ack);
            @(posedge clk);
            model_clock(tbl[i].md, tbl[i].sel, tbl[i].vin, tbl[i].din, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d valid", i), valid_out, tbl[i].e_valid);
            chk($sformatf("vec%0d data", i),  data_out,  tbl[i].e_data);
            chk($sformatf("vec%0d grant", i), grant_out, tbl[i].e_grant);
            chk($sformatf("vec%0d count", i), count_out, tbl[i].e_count);
        end

        // Round robin with every channel valid and the output always drained.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'hF, 8'hE4, 1);
            chk($sformatf("rr grant%0d", i), grant_out, g_exp[i]);
        end

        // Five-cycle stall with every channel requesting: everything frozen.
        step(0, 1, 4'hF, 8'hE4, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'hF, $urandom, 0);
            chk("stall ack", ack_out, 0);
            chk("stall data", data_out, 1);
            chk("stall grant", grant_out, 1);
            chk("stall count", count_out, 6);
        end
        step(1, 0, 4'hF, 8'hE4, 1);

        // Reset asserted between edges while a transfer is held.
        chk("pre-reset valid", valid_out, 1);
        reset_L = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();

        // 256 consecutive loads bring the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 4'b0001, $urandom, 1);
            if (i == 254) chk("count 255", count_out, 255);
        end
        chk("count wrap", count_out, 0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, C - 1), $urandom_range(0, 15),
                 $urandom, ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_arb_param.md
MUX_ARB_PARAM -- requirements
Module: mux_arb_param

Interface
REQ-001 Parameter WIDTH, default 2: data width per channel, legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of input channels, a power of two, legal range 2..16.
REQ-003 Derived value SELW = log2(CHANNELS): width of selector and grant fields.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port mode, input, 1 bit: 0 = fixed selection, 1 = round-robin arbitration.
REQ-007 Port selector, input, SELW bits: channel to pass in mode 0; ignored in mode 1.
REQ-008 Port data_in, input, WIDTH*CHANNELS bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port valid_in, input, CHANNELS bits: bit i set means channel i offers data.
REQ-010 Port ready_in, input, 1 bit: downstream accepts data_out this cycle.
REQ-011 Port ack_out, output, CHANNELS bits: one-hot or zero; bit i set means channel i is consumed at the next rising edge.
REQ-012 Port data_out, output, WIDTH bits: registered output data.
REQ-013 Port valid_out, output, 1 bit: registered; data_out holds a transfer.
REQ-014 Port grant_out, output, SELW bits: registered; source channel of the current data_out.
REQ-015 Port count_out, output, 8 bits: registered count of completed loads.

Function
REQ-016 Output register shall be free when valid_out=0 or ready_in=1.
REQ-017 Mode 0 candidate shall be the selector channel, only if valid_in[selector]=1; other valid channels are ignored.
REQ-018 Mode 1 candidate shall be the first channel with valid_in set, searched from ptr upward modulo CHANNELS.
REQ-019 Load shall occur when the output register is free and a candidate exists; ack_out shall then be the candidate's one-hot bit, combinational, otherwise all zero.
REQ-020 On a load at the rising edge: data_out <= candidate data, valid_out <= 1, grant_out <= candidate index, count_out <= count_out+1; latency is 1 cycle from ack_out to valid_out.
REQ-021 count_out shall wrap from 255 to 0.
REQ-022 With valid_out=1 and ready_in=0 (stall): data_out, valid_out, grant_out, count_out and ptr hold; ack_out=0.
REQ-023 With valid_out=1, ready_in=1 and no candidate: valid_out <= 0; data_out and grant_out hold their last values.
REQ-024 ptr shall be an internal SELW-bit register; after a mode 1 load from channel k, ptr <= (k+1) mod CHANNELS.
REQ-025 ptr shall be unchanged on no load and on any mode 0 load.
REQ-026 A mode change shall take effect combinationally in the same cycle; ptr is retained across mode changes.
REQ-027 valid_in changing during a stall shall have no effect until the register is free; no data is lost or duplicated.

Reset
REQ-028 While reset_L=0: data_out=0, valid_out=0, grant_out=0, count_out=0, ptr=0, ack_out=0, independent of clk.
REQ-029 Reset asserted mid-transfer shall discard the held data immediately.
REQ-030 The first load is permitted on the first rising edge after reset_L rises.

Verification (WIDTH=2, CHANNELS=4)
REQ-031 Mode 0, selector=2, valid_in=0110, ch2=11, ready_in=1 -> ack_out=0100; next edge data_out=11, grant_out=2, valid_out=1, count_out=1.
REQ-032 Mode 1, valid_in=1111, ready_in=1 held -> grant_out sequence 0,1,2,3,0 on consecutive edges.
REQ-033 Mode 1, ptr=1, valid_in=1001 -> grant 3 and ptr=0, then grant 0 and ptr=1.
REQ-034 valid_out=1, ready_in=0 for 5 cycles with valid_in=1111 -> outputs frozen, ack_out=0000, count_out unchanged.
REQ-035 256 consecutive loads -> count_out returns to 0.
REQ-036 reset_L pulled low between edges while valid_out=1 -> all outputs 0 immediately, before the next edge.
